// File: rtl/fht_loader.sv
// fht_loader
// ----------
// Input-side frame loader for the FHT core. Accepts unextended ADC samples
// over a valid/ready handshake and scatters each N-point frame
// (N = 4 * 2^A_BIT) across the four RAM(A) banks of fht_top. Once the last
// sample of a frame has been written, it issues a one-cycle start strobe.
// It then holds the stream off until the transform reports ready again.
//
// Optional feature macro: FHT_LOAD_BITREV_EN
//   defined   : the sample index is bit-reversed over A_BIT+2 bits before the
//               bank/address split, so the input permutation is done here.
//   undefined : natural order; the downstream stage handles any reordering.
//
// Ports
//   iCLK         single clock
//   iRESET       synchronous, active-high reset
//   iDATA        ADC sample (D_BIT-1 bits, passed through unextended)
//   iVALID       sample valid
//   oREADY       loader accepts a sample this cycle
//   iFHT_RDY     oRDY of fht_top
//   oDATA        write data to fht_top
//   oADDR_WR     per-bank write address to fht_top
//   oWE_0..oWE_3 bank write enables (one-hot on a write, else all low)
//   oSTART       one-cycle start strobe to fht_top
//   oBUSY        high while waiting for the transform to complete
//   oFRAME_DONE  one-cycle pulse when the transform completes
//   oFRAME_CNT   completed-frame counter, wraps 0xFFFF -> 0
module fht_loader #(
  parameter int D_BIT = 17,
  parameter int A_BIT = 8
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-2:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic             iFHT_RDY,
  output logic [D_BIT-2:0] oDATA,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic             oWE_0,
  output logic             oWE_1,
  output logic             oWE_2,
  output logic             oWE_3,
  output logic             oSTART,
  output logic             oBUSY,
  output logic             oFRAME_DONE,
  output logic [15:0]      oFRAME_CNT
);

  localparam int N_BIT = A_BIT + 2;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    FIRE     = 2'd1,
    WAIT_LOW = 2'd2,
    WAIT_HI  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [N_BIT-1:0] sample_idx;
  logic [N_BIT-1:0] word_idx;
  logic             xfer;
  logic             last_sample;
  logic             in_wait;

  // oREADY is a registered copy of (state == LOAD), so this is exactly the
  // handshake condition seen by the upstream source.
  assign xfer        = iVALID && oREADY;
  assign last_sample = &sample_idx;
  assign in_wait     = (state == WAIT_LOW) || (state == WAIT_HI);

  // Map the sample index onto a RAM word; low two bits select the bank.
`ifdef FHT_LOAD_BITREV_EN
  always_comb begin
    word_idx = '0;
    for (int i = 0; i < N_BIT; i++) begin
      word_idx[i] = sample_idx[N_BIT-1-i];
    end
  end
`else
  always_comb begin
    word_idx = sample_idx;
  end
`endif

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  // WAIT_LOW swallows a ready left over from the previous frame, so that
  // only a fresh low->high edge of iFHT_RDY completes this frame.
  always_comb begin
    next_state = state;
    case (state)
      LOAD:     if (xfer && last_sample) next_state = FIRE;
      FIRE:     next_state = WAIT_LOW;
      WAIT_LOW: if (!iFHT_RDY) next_state = WAIT_HI;
      WAIT_HI:  if (iFHT_RDY) next_state = LOAD;
      default:  next_state = LOAD;
    endcase
  end

  // Registered handshake/status outputs. oSTART follows one cycle behind
  // FIRE so the final RAM write has landed before the core starts. oBUSY
  // drops in the same cycle as oFRAME_DONE, when the state returns to LOAD.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      oREADY      <= 1'b1;
      oSTART      <= 1'b0;
      oBUSY       <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oFRAME_CNT  <= '0;
    end else begin
      oREADY      <= (next_state == LOAD);
      oSTART      <= (state == FIRE);
      oBUSY       <= in_wait && (next_state != LOAD);
      oFRAME_DONE <= (state == WAIT_HI) && iFHT_RDY;
      if ((state == WAIT_HI) && iFHT_RDY) begin
        oFRAME_CNT <= oFRAME_CNT + 16'd1;
      end
    end
  end

  // Write path. Each accepted sample produces exactly one single-cycle
  // write. Data and address are zeroed between writes so that stale values
  // never accompany an idle cycle. The index wraps naturally to 0 after N-1.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      sample_idx <= '0;
      oDATA      <= '0;
      oADDR_WR   <= '0;
      oWE_0      <= 1'b0;
      oWE_1      <= 1'b0;
      oWE_2      <= 1'b0;
      oWE_3      <= 1'b0;
    end else if (xfer) begin
      sample_idx <= sample_idx + 1'b1;
      oDATA      <= iDATA;
      oADDR_WR   <= word_idx[N_BIT-1:2];
      oWE_0      <= (word_idx[1:0] == 2'd0);
      oWE_1      <= (word_idx[1:0] == 2'd1);
      oWE_2      <= (word_idx[1:0] == 2'd2);
      oWE_3      <= (word_idx[1:0] == 2'd3);
    end else begin
      oDATA      <= '0;
      oADDR_WR   <= '0;
      oWE_0      <= 1'b0;
      oWE_1      <= 1'b0;
      oWE_2      <= 1'b0;
      oWE_3      <= 1'b0;
    end
  end

endmodule
